tc141_sfifox: RTL and testbench
===============================

// Module: tc141_sfifox
// PURPOSE
//  Variable width/depth synchronous FIFO with registered read data; elastic buffer feeding
//  the fixed-latency register stages of the wrapmont datapath (operand/result staging).
//  Absorbs bursty producer writes and delivers words to the consumer 1 cycle after a read
//  request. Single clock domain; occupancy level and almost-full/almost-empty flags provided.
// PARAMETERS
//  WIDTH      8          data word width, >=1
//  DEPTH      16         storage entries; power of 2, >=2
//  AW         log2(DEPTH) address width; derived localparam, not overridden
//  AFULL_LVL  DEPTH-2    oafull asserted when level >= AFULL_LVL
//  AEMPTY_LVL 2          oaempty asserted when level <= AEMPTY_LVL
// PORTS
//  clk      in   1       clock, all logic on rising edge
//  rst_     in   1       synchronous reset, active-high
//  iwr      in   1       write request
//  idat     in   WIDTH   write data, sampled with iwr
//  ird      in   1       read request
//  odat     out  WIDTH   read data, registered
//  ovld     out  1       odat valid, 1-cycle pulse per accepted read
//  ofull    out  1       level == DEPTH
//  oempty   out  1       level == 0
//  oafull   out  1       level >= AFULL_LVL
//  oaempty  out  1       level <= AEMPTY_LVL
//  olevel   out  AW+1    current occupancy, 0..DEPTH
//  oovf     out  1       1-cycle pulse: write dropped (full)
//  oudf     out  1       1-cycle pulse: read ignored (empty)
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high (rst_=1 sampled at clk edge).
//  - Reset: wptr=rptr=0, olevel=0, oempty=1, oaempty=1, ofull=0, oafull=0, ovld=0,
//    odat=0, oovf=0, oudf=0. Storage array not reset. Reset mid-traffic discards all
//    contents; iwr/ird in the reset cycle are ignored.
//  - Pointers AW+1 bits, wrap naturally mod 2*DEPTH; array indexed by low AW bits.
//    olevel = wptr - rptr (AW+1-bit modular subtract).
//  - Write accepted (wa) = iwr & (~ofull | ird): stores idat at wptr, wptr+1.
//  - Read accepted (ra) = ird & ~oempty: odat <= mem[rptr] next cycle, ovld=1, rptr+1.
//  - Read latency: ird at edge N accepted -> odat/ovld valid after edge N+1, single cycle.
//    odat holds last value when ovld=0.
//  - Level next = level + wa - ra; all flags registered from level-next, so flags and
//    olevel are coherent in the same cycle.
//  - Full + iwr + ird: both accepted, level stays DEPTH, no oovf.
//  - Full + iwr, no ird: write dropped, oovf=1 next cycle, contents unchanged.
//  - Empty + ird: read ignored, oudf=1 next cycle, ovld=0. No write-to-read bypass:
//    empty + iwr + ird -> write accepted, read ignored (oudf=1), level=1.
//  - oovf/oudf are pulses, not sticky; counting is the integrator's task.
//  - AFULL_LVL/AEMPTY_LVL outside 0..DEPTH: flags constant, no error raised.
// STRUCTURE
//  - Shared package/include: clog2 function for AW, flag-threshold defaults.
//  - Sub-module tc141_sfifox_ram: DEPTH x WIDTH array, 1 write port, registered read
//    port (rd_en, rd_addr -> rd_dat next cycle), no reset on storage.
//  - Top: pointer/level counters, flag registers, error pulses, ovld register.
// TESTING
//  - Reset, then write 0x11,0x22,0x33 then 3 reads -> odat 0x11,0x22,0x33 each 1 cycle
//    after ird, ovld pulses, olevel 3->0, oempty=1.
//  - DEPTH=16: 16 writes -> ofull=1, olevel=16, oafull from level 14; 17th write ->
//    oovf=1, subsequent 16 reads return original 16 words in order.
//  - Full + iwr=ird=1 for 40 cycles -> no oovf, olevel stays 16, data in order across
//    pointer wrap (>2*DEPTH ops).
//  - Empty + ird -> oudf=1, ovld=0; empty + iwr(0xA5)+ird -> oudf=1, olevel=1, next read
//    returns 0xA5.
//  - 10 words loaded, rst_=1 one cycle with iwr/ird active -> all outputs at reset values,
//    next read gives oudf=1.
//  - Random iwr/ird 10k cycles vs. reference queue model: data order, olevel, all flags.

Source files
------------

// File: rtl/tc141_sfifox_pkg.sv
// Shared definitions for the tc141_sfifox synchronous FIFO:
// default sizing, flag thresholds, flag bundle type and clog2 helper.
package tc141_sfifox_pkg;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_DEPTH      = 16;
    localparam int DEF_AEMPTY_LVL = 2;

    // Registered status flags, all derived from the same next level.
    typedef struct packed {
        logic full;
        logic empty;
        logic afull;
        logic aempty;
    } flags_t;

    localparam flags_t FLAGS_RST = '{
        full:   1'b0,
        empty:  1'b1,
        afull:  1'b0,
        aempty: 1'b1
    };

    // Ceiling log2 for constant parameter evaluation.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tc141_sfifox_ram.sv
// Storage for tc141_sfifox: DEPTH x WIDTH array, one write port and
// one registered read port (i_rd_en/i_rd_addr -> o_rd_dat next cycle).
// Ports:
//   clk        clock
//   i_rst      sync active-high reset, clears only the read register
//   i_wr_en    write enable
//   i_wr_addr  write address
//   i_wr_dat   write data
//   i_rd_en    read enable
//   i_rd_addr  read address
//   o_rd_dat   registered read data, holds when i_rd_en=0
module tc141_sfifox_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_dat,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_dat
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_dat;

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
    end

    // Read-before-write: a read of the slot being written in the same
    // cycle (full FIFO with simultaneous push/pop) returns the old word.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_rd_dat <= '0;
        end else if (i_rd_en) begin
            r_rd_dat <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/tc141_sfifox.sv
// Synchronous FIFO with registered read data, occupancy level,
// almost-full/almost-empty flags and overflow/underflow pulses.
// Ports:
//   clk      clock, rising edge
//   rst_     synchronous reset, active-high
//   iwr      write request, idat sampled with it
//   idat     write data [WIDTH]
//   ird      read request
//   odat     registered read data, holds when ovld=0
//   ovld     1-cycle pulse per accepted read
//   ofull    level == DEPTH
//   oempty   level == 0
//   oafull   level >= AFULL_LVL
//   oaempty  level <= AEMPTY_LVL
//   olevel   occupancy 0..DEPTH [AW+1]
//   oovf     pulse: write dropped while full
//   oudf     pulse: read ignored while empty
module tc141_sfifox
    import tc141_sfifox_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AFULL_LVL  = DEPTH - 2,
    parameter int AEMPTY_LVL = DEF_AEMPTY_LVL
) (
    input  logic                       clk,
    input  logic                       rst_,
    input  logic                       iwr,
    input  logic [WIDTH-1:0]           idat,
    input  logic                       ird,
    output logic [WIDTH-1:0]           odat,
    output logic                       ovld,
    output logic                       ofull,
    output logic                       oempty,
    output logic                       oafull,
    output logic                       oaempty,
    output logic [clog2(DEPTH):0]      olevel,
    output logic                       oovf,
    output logic                       oudf
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra bit so full and empty differ.
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    flags_t      r_flg;
    logic        r_vld;
    logic        r_ovf;
    logic        r_udf;

    logic [AW:0] w_level;
    logic [AW:0] w_level_nxt;
    int          w_lvl_i;
    logic        w_wa;
    logic        w_ra;
    flags_t      w_flg_nxt;

    // A full FIFO still accepts a write when a read frees a slot
    // in the same cycle.
    assign w_wa = iwr & (~r_flg.full | ird);
    assign w_ra = ird & ~r_flg.empty;

    assign w_level     = r_wptr - r_rptr;
    assign w_level_nxt = w_level
                       + {{AW{1'b0}}, w_wa}
                       - {{AW{1'b0}}, w_ra};
    assign w_lvl_i     = int'(w_level_nxt);

    // Signed int compares keep out-of-range thresholds constant.
    always_comb begin
        w_flg_nxt        = FLAGS_RST;
        w_flg_nxt.full   = (w_lvl_i == DEPTH);
        w_flg_nxt.empty  = (w_lvl_i == 0);
        w_flg_nxt.afull  = (w_lvl_i >= AFULL_LVL);
        w_flg_nxt.aempty = (w_lvl_i <= AEMPTY_LVL);
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_flg  <= FLAGS_RST;
            r_vld  <= 1'b0;
            r_ovf  <= 1'b0;
            r_udf  <= 1'b0;
        end else begin
            if (w_wa) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_ra) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            r_flg <= w_flg_nxt;
            r_vld <= w_ra;
            r_ovf <= iwr & ~w_wa;
            r_udf <= ird & r_flg.empty;
        end
    end

    tc141_sfifox_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk       (clk),
        .i_rst     (rst_),
        .i_wr_en   (w_wa & ~rst_),
        .i_wr_addr (r_wptr[AW-1:0]),
        .i_wr_dat  (idat),
        .i_rd_en   (w_ra & ~rst_),
        .i_rd_addr (r_rptr[AW-1:0]),
        .o_rd_dat  (odat)
    );

    assign ovld    = r_vld;
    assign ofull   = r_flg.full;
    assign oempty  = r_flg.empty;
    assign oafull  = r_flg.afull;
    assign oaempty = r_flg.aempty;
    assign olevel  = w_level;
    assign oovf    = r_ovf;
    assign oudf    = r_udf;

endmodule

// File: tb/tb_tc141_sfifox.sv
// Directed and model-based bench for tc141_sfifox (WIDTH=8, DEPTH=16).
// Inputs change #1 after the rising edge; outputs are sampled there too.
module tb_tc141_sfifox;

    logic       clk = 1'b0;
    logic       rst_;
    logic       iwr;
    logic [7:0] idat;
    logic       ird;
    logic [7:0] odat;
    logic       ovld;
    logic       ofull;
    logic       oempty;
    logic       oafull;
    logic       oaempty;
    logic [4:0] olevel;
    logic       oovf;
    logic       oudf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tc141_sfifox dut (
        .clk     (clk),
        .rst_    (rst_),
        .iwr     (iwr),
        .idat    (idat),
        .ird     (ird),
        .odat    (odat),
        .ovld    (ovld),
        .ofull   (ofull),
        .oempty  (oempty),
        .oafull  (oafull),
        .oaempty (oaempty),
        .olevel  (olevel),
        .oovf    (oovf),
        .oudf    (oudf)
    );

    task automatic cyc(input logic w, input logic [7:0] d, input logic r);
        iwr  = w;
        idat = d;
        ird  = r;
        @(posedge clk);
        #1;
    endtask

    // {ovld,ofull,oempty,oafull,oaempty,oovf,oudf}
    task automatic test_reset();
        rst_ = 1'b1;
        cyc(1'b1, 8'hFF, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        rst_ = 1'b0;
        checks++;
        if ({ovld, ofull, oempty, oafull, oaempty, oovf, oudf} !== 7'b0010100) begin
            errors++;
            $display("FAIL reset_flags got %b exp %b",
                     {ovld, ofull, oempty, oafull, oaempty, oovf, oudf}, 7'b0010100);
        end
        checks++;
        if (olevel !== 5'd0 || odat !== 8'h00) begin
            errors++;
            $display("FAIL reset_level_dat got %0d/%h exp 0/00", olevel, odat);
        end
    endtask

    task automatic test_basic();
        logic [7:0] wv [3];
        wv[0] = 8'h11;
        wv[1] = 8'h22;
        wv[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, wv[i], 1'b0);
            checks++;
            if (olevel !== 5'(i + 1) || ovld !== 1'b0) begin
                errors++;
                $display("FAIL basic_wr%0d got lvl %0d vld %b exp %0d 0",
                         i, olevel, ovld, i + 1);
            end
        end
        checks++;
        if (oempty !== 1'b0 || oaempty !== 1'b0) begin
            errors++;
            $display("FAIL basic_flags3 got e %b ae %b exp 0 0", oempty, oaempty);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            checks++;
            if (odat !== wv[i] || ovld !== 1'b1 || olevel !== 5'(2 - i)) begin
                errors++;
                $display("FAIL basic_rd%0d got %h/%b/%0d exp %h/1/%0d",
                         i, odat, ovld, olevel, wv[i], 2 - i);
            end
        end
        cyc(1'b0, 8'h00, 1'b0);
        checks++;
        if (oempty !== 1'b1 || ovld !== 1'b0 || odat !== 8'h33) begin
            errors++;
            $display("FAIL basic_idle got e %b v %b d %h exp 1 0 33",
                     oempty, ovld, odat);
        end
    endtask

    task automatic test_full();
        logic [7:0] e8;
        logic       eaf;
        for (int k = 1; k <= 16; k++) begin
            e8 = 8'(8'h40 + k - 1);
            cyc(1'b1, e8, 1'b0);
            eaf = (k >= 14);
            checks++;
            if (olevel !== 5'(k) || oafull !== eaf || ofull !== (k == 16)) begin
                errors++;
                $display("FAIL full_wr%0d got lvl %0d af %b f %b exp %0d %b %b",
                         k, olevel, oafull, ofull, k, eaf, k == 16);
            end
        end
        cyc(1'b1, 8'hEE, 1'b0);
        checks++;
        if (oovf !== 1'b1 || olevel !== 5'd16 || ofull !== 1'b1) begin
            errors++;
            $display("FAIL full_ovf got ovf %b lvl %0d f %b exp 1 16 1",
                     oovf, olevel, ofull);
        end
        cyc(1'b0, 8'h00, 1'b0);
        checks++;
        if (oovf !== 1'b0) begin
            errors++;
            $display("FAIL full_ovf_pulse got %b exp 0", oovf);
        end
        for (int j = 0; j < 16; j++) begin
            e8 = 8'(8'h40 + j);
            cyc(1'b0, 8'h00, 1'b1);
            checks++;
            if (odat !== e8 || ovld !== 1'b1) begin
                errors++;
                $display("FAIL full_rd%0d got %h/%b exp %h/1", j, odat, ovld, e8);
            end
        end
        checks++;
        if (oempty !== 1'b1 || olevel !== 5'd0 || ofull !== 1'b0) begin
            errors++;
            $display("FAIL full_drain got e %b lvl %0d f %b exp 1 0 0",
                     oempty, olevel, ofull);
        end
    endtask

    task automatic test_full_rw();
        logic [7:0] e8;
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, 8'(8'h80 + k), 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            e8 = 8'(8'h80 + i);
            cyc(1'b1, 8'(8'h90 + i), 1'b1);
            checks++;
            if (odat !== e8 || ovld !== 1'b1 || oovf !== 1'b0 ||
                olevel !== 5'd16 || ofull !== 1'b1) begin
                errors++;
                $display("FAIL fullrw%0d got %h v %b ovf %b lvl %0d f %b exp %h 1 0 16 1",
                         i, odat, ovld, oovf, olevel, ofull, e8);
            end
        end
        for (int j = 0; j < 16; j++) begin
            e8 = 8'(8'h80 + 40 + j);
            cyc(1'b0, 8'h00, 1'b1);
            checks++;
            if (odat !== e8 || ovld !== 1'b1) begin
                errors++;
                $display("FAIL fullrw_drain%0d got %h/%b exp %h/1", j, odat, ovld, e8);
            end
        end
    endtask

    task automatic test_underflow();
        cyc(1'b0, 8'h00, 1'b1);
        checks++;
        if (oudf !== 1'b1 || ovld !== 1'b0 || olevel !== 5'd0) begin
            errors++;
            $display("FAIL udf_empty got udf %b v %b lvl %0d exp 1 0 0",
                     oudf, ovld, olevel);
        end
        cyc(1'b1, 8'hA5, 1'b1);
        checks++;
        if (oudf !== 1'b1 || ovld !== 1'b0 || olevel !== 5'd1 || oempty !== 1'b0) begin
            errors++;
            $display("FAIL udf_wr_rd got udf %b v %b lvl %0d e %b exp 1 0 1 0",
                     oudf, ovld, olevel, oempty);
        end
        cyc(1'b0, 8'h00, 1'b1);
        checks++;
        if (odat !== 8'hA5 || ovld !== 1'b1 || oudf !== 1'b0) begin
            errors++;
            $display("FAIL udf_readback got %h v %b udf %b exp a5 1 0",
                     odat, ovld, oudf);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, 8'(8'hC0 + k), 1'b0);
        end
        cyc(1'b0, 8'h00, 1'b1);
        rst_ = 1'b1;
        cyc(1'b1, 8'h5A, 1'b1);
        rst_ = 1'b0;
        checks++;
        if ({ovld, ofull, oempty, oafull, oaempty, oovf, oudf} !== 7'b0010100 ||
            olevel !== 5'd0 || odat !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_state got %b lvl %0d d %h exp 0010100 0 00",
                     {ovld, ofull, oempty, oafull, oaempty, oovf, oudf}, olevel, odat);
        end
        cyc(1'b0, 8'h00, 1'b1);
        checks++;
        if (oudf !== 1'b1 || ovld !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_udf got udf %b v %b exp 1 0", oudf, ovld);
        end
    endtask

    task automatic test_random();
        logic [7:0] q [$];
        logic [7:0] exp_dat;
        logic [7:0] d;
        logic       w, r, wa, ra, fm, em;
        logic [20:0] got, exp;
        int         pw, lvl;
        rst_ = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        rst_ = 1'b0;
        exp_dat = 8'h00;
        for (int i = 0; i < 10000; i++) begin
            pw = ((i / 500) % 2 == 1) ? 75 : 25;
            w  = ($urandom_range(0, 99) < pw);
            r  = ($urandom_range(0, 99) < (100 - pw));
            d  = 8'($urandom_range(0, 255));
            fm = (q.size() == 16);
            em = (q.size() == 0);
            wa = w && (!fm || r);
            ra = r && !em;
            if (ra) exp_dat = q.pop_front();
            if (wa) q.push_back(d);
            lvl = q.size();
            cyc(w, d, r);
            exp = {exp_dat, ra, lvl == 16, lvl == 0, lvl >= 14, lvl <= 2,
                   w && !wa, r && em, 5'(lvl)};
            got = {odat, ovld, ofull, oempty, oafull, oaempty, oovf, oudf, olevel};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rand%0d got %h exp %h", i, got, exp);
            end
        end
    endtask

    initial begin
        rst_ = 1'b1;
        iwr  = 1'b0;
        idat = 8'h00;
        ird  = 1'b0;
        test_reset();
        test_basic();
        test_full();
        test_full_rw();
        test_underflow();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
